// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch buffer:
//   IF_ADDR_W / IF_INSTR_W : default PC and instruction widths
//   state_t                : fetch FSM encoding (IDLE, REQ, DROP)
//   entry_t                : buffered FIFO entry {addr, instr} at default widths
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int IF_ADDR_W  = 16;
  localparam int IF_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0]  addr;
    logic [IF_INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer_if
// Bundles the instruction-memory handshake and the IF/ID valid/ready output.
//   imem_req / imem_addr      : fetch request and address (fetch buffer -> memory)
//   imem_ack / imem_rdata     : response strobe and instruction word (memory -> buffer)
//   id_valid / id_instr / id_pc : FIFO head presented to IF/ID
//   id_ready                  : IF/ID accepts the head
// Modports:
//   master : the fetch buffer side
//   slave  : the memory + IF/ID side
// -----------------------------------------------------------------------------
interface if_fetch_buffer_if
  import if_pkg::*;
#(
  parameter int ADDR_W  = IF_ADDR_W,
  parameter int INSTR_W = IF_INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );

endinterface

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Small synchronous FIFO with a combinationally read head.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (pointers and count)
//   i_push   : write i_data at the tail (caller guarantees a free slot)
//   i_pop    : drop the head (ignored when empty)
//   i_clear  : empty the FIFO at the next edge; wins over push and pop
//   o_count  : number of stored entries (0..DEPTH)
//   o_valid  : FIFO not empty
//   o_head   : head entry
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module if_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries data only, so it is left out of the reset domain.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer
// Consumer end of the PC: issues one instruction fetch at a time over a
// req/ack handshake, buffers {address, instruction} in a FIFO and presents
// the head to IF/ID with valid/ready. pc_ce advances the PC only when a
// fetch is issued. flush discards buffered entries and any in-flight fetch.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   pc_in    : current PC value, latched as the fetch address on pc_ce
//   pc_ce    : PC load enable, high in the cycle a fetch is issued
//   flush    : redirect, drops FIFO contents and the outstanding fetch
//   bus      : if_fetch_buffer_if.master (imem_* handshake, id_* output)
// Build option:
//   IF_BACK_TO_BACK_EN : when defined, an ack in REQ may issue the next fetch
//                        in the same cycle, keeping imem_req high continuously.
// -----------------------------------------------------------------------------
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int ADDR_W  = IF_ADDR_W,
  parameter int INSTR_W = IF_INSTR_W,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ce,
  input  logic              flush,
  if_fetch_buffer_if.master bus
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam int               ENT_W   = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count;
  logic               w_head_vld;
  logic [ENT_W-1:0]   w_head;

  assign w_pop = w_head_vld & bus.id_ready;

  // The FIFO count excludes the outstanding fetch, but a fetch is only issued
  // while count < DEPTH, so its slot is implicitly reserved and a push can
  // never land on a full FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && (w_count < DEPTH_C)) begin
          w_issue     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          w_state_nxt = IDLE;
          if (!flush) begin
            w_push = 1'b1;
`ifdef IF_BACK_TO_BACK_EN
            // Occupancy after this edge is count + push - pop; the new fetch
            // needs one more free slot beyond that.
            if ((w_count + CNT_W'(1) - CNT_W'(w_pop)) < DEPTH_C) begin
              w_issue     = 1'b1;
              w_state_nxt = REQ;
            end
`endif
          end
        end else if (flush) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        // Memory still owes a response for the abandoned fetch; wait for it.
        if (bus.imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_addr <= pc_in;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  ({r_addr, bus.imem_rdata}),
    .o_count (w_count),
    .o_valid (w_head_vld),
    .o_head  (w_head)
  );

  // IDLE would otherwise raise pc_ce combinationally while reset is held.
  assign pc_ce         = w_issue & ~rst;
  assign bus.imem_req  = (r_state == REQ) || (r_state == DROP);
  assign bus.imem_addr = r_addr;
  assign bus.id_valid  = w_head_vld;
  // Head is forced to zero when empty so unwritten storage never shows.
  assign {bus.id_pc, bus.id_instr} = w_head_vld ? w_head : '0;

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
`ifdef IF_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          pc_ce;
  logic [AW-1:0] pc_in;

  if_fetch_buffer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  if_fetch_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_in (pc_in),
    .pc_ce (pc_ce),
    .flush (flush),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state (transaction level)
  entry_t        exp_q[$];
  bit            outst   = 1'b0;
  bit            dropped = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [AW-1:0] bench_pc = '0;
  logic [AW-1:0] reset_pc = '0;
  logic [AW-1:0] redirect_pc = '0;
  int            ce_cnt = 0;
  logic [AW-1:0] pop_log[$];

  // Memory responder knobs
  int            lat_min = 0;
  int            lat_max = 0;
  int            mem_wait = -1;
  bit            fix_en = 1'b0;
  logic [IW-1:0] fix_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor: compare DUT against the model, then advance the model.
  always @(negedge clk) begin
    bit     mvalid;
    bit     mpop;
    bit     ece;
    entry_t e;
    if (rst) begin
      chk("rst_pc_ce", pc_ce, 0);
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_imem_addr", bus.imem_addr, 0);
      chk("rst_id_valid", bus.id_valid, 0);
      chk("rst_id_instr", bus.id_instr, 0);
      chk("rst_id_pc", bus.id_pc, 0);
      exp_q.delete();
      outst    = 1'b0;
      dropped  = 1'b0;
      bench_pc = reset_pc;
    end else begin
      mvalid = (exp_q.size() != 0);
      chk("id_valid", bus.id_valid, mvalid);
      if (mvalid) begin
        chk("id_pc", bus.id_pc, exp_q[0].addr);
        chk("id_instr", bus.id_instr, exp_q[0].instr);
      end
      mpop = mvalid && bus.id_ready;
      ece  = 1'b0;
      if (!outst)
        ece = !flush && (exp_q.size() < DEPTH);
      else if (B2B && bus.imem_ack && !flush && !dropped)
        ece = (exp_q.size() + 1 - int'(mpop)) < DEPTH;
      chk("pc_ce", pc_ce, ece);
      chk("imem_req", bus.imem_req, outst);
      if (outst) chk("imem_addr", bus.imem_addr, iss_addr);
      if (pc_ce) ce_cnt++;
      if (bus.id_valid && bus.id_ready && !flush) pop_log.push_back(bus.id_pc);
      if (mpop) void'(exp_q.pop_front());
      if (outst && bus.imem_ack) begin
        if (!flush && !dropped) begin
          e.addr  = iss_addr;
          e.instr = bus.imem_rdata;
          exp_q.push_back(e);
        end
        outst   = 1'b0;
        dropped = 1'b0;
      end else if (outst && flush) begin
        dropped = 1'b1;
      end
      if (flush) exp_q.delete();
      if (ece) begin
        outst    = 1'b1;
        iss_addr = pc_in;
        bench_pc = pc_in + AW'(1);
      end
      if (flush) bench_pc = redirect_pc;
    end
  end

  // One clock of stimulus, including the memory responder.
  task automatic tick(input bit r, input bit fl, input bit rdy, input bit force_ack);
    @(posedge clk);
    #1;
    rst          = r;
    flush        = fl;
    bus.id_ready = rdy;
    pc_in        = bench_pc;
    bus.imem_rdata = fix_en ? fix_data : IW'($urandom);
    bus.imem_ack = 1'b0;
    if (r) begin
      mem_wait = -1;
    end else if (force_ack) begin
      bus.imem_ack = 1'b1;
    end else if (bus.imem_req) begin
      if (mem_wait < 0) mem_wait = $urandom_range(lat_max, lat_min);
      if (mem_wait == 0) begin
        bus.imem_ack = 1'b1;
        mem_wait     = -1;
      end else begin
        mem_wait--;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int pl0;
    bit found;
    rst = 1'b1; flush = 1'b0; pc_in = '0;
    bus.id_ready = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    // Single fetch, zero-latency memory
    reset_pc = 16'h0010; fix_en = 1'b1; fix_data = 16'hA5A5; lat_min = 0; lat_max = 0;
    repeat (3) tick(1, 0, 1, 0);
    c0 = ce_cnt;
    tick(0, 0, 1, 0); sample();
    chk("t1_ce_pulse", ce_cnt - c0, 1);
    tick(0, 0, 1, 0); sample();
    chk("t1_imem_addr", bus.imem_addr, 16'h0010);
    chk("t1_imem_req", bus.imem_req, 1);
    tick(0, 0, 1, 0); sample();
    chk("t1_id_valid", bus.id_valid, 1);
    chk("t1_id_instr", bus.id_instr, 16'hA5A5);
    chk("t1_id_pc", bus.id_pc, 16'h0010);

    // FIFO fills with id_ready low, then drains in order
    reset_pc = 16'h0000; fix_en = 1'b0;
    repeat (2) tick(1, 0, 0, 0);
    c0 = ce_cnt;
    repeat (14) tick(0, 0, 0, 0);
    sample();
    chk("t2_ce_pulses", ce_cnt - c0, 4);
    chk("t2_req_idle", bus.imem_req, 0);
    chk("t2_id_valid", bus.id_valid, 1);
    pl0 = pop_log.size();
    repeat (6) tick(0, 0, 1, 0);
    sample();
    chk("t2_pop_count", (pop_log.size() >= pl0 + 4), 1);
    if (pop_log.size() >= pl0 + 4)
      for (int i = 0; i < 4; i++) chk("t2_pop_order", pop_log[pl0+i], i);

    // Flush in REQ without ack; late ack must be dropped
    reset_pc = 16'h0000; redirect_pc = 16'h0040; fix_en = 1'b1; fix_data = 16'hDEAD;
    lat_min = 3; lat_max = 3;
    repeat (2) tick(1, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 1, 1, 0); sample();
    chk("t3_ce_flush", pc_ce, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0); sample();
      chk("t3_drop_req", bus.imem_req, 1);
      chk("t3_drop_valid", bus.id_valid, 0);
    end
    tick(0, 0, 1, 0); sample();
    chk("t3_no_push", bus.id_valid, 0);
    chk("t3_refetch_ce", pc_ce, 1);
    tick(0, 0, 1, 0); sample();
    chk("t3_redirect_addr", bus.imem_addr, 16'h0040);

    // Flush coincident with ack while two entries are buffered
    reset_pc = 16'h0200; redirect_pc = 16'h0100; fix_en = 1'b0;
    lat_min = 0; lat_max = 0;
    repeat (2) tick(1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(0, 0, 0, 0); sample();
      if (exp_q.size() == 2 && outst) found = 1'b1;
    end
    chk("t4_setup", found, 1);
    tick(0, 1, 0, 0); sample();
    chk("t4_ce_flush", pc_ce, 0);
    chk("t4_valid_before", bus.id_valid, 1);
    tick(0, 0, 0, 0); sample();
    chk("t4_cleared", bus.id_valid, 0);

    // Reset while in REQ, then a stale ack
    reset_pc = 16'h1234; lat_min = 5; lat_max = 5;
    repeat (2) tick(1, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0); sample();
    chk("t5_in_req", bus.imem_req, 1);
    tick(1, 0, 1, 0); sample();
    chk("t5_req_rst", bus.imem_req, 0);
    chk("t5_addr_rst", bus.imem_addr, 0);
    chk("t5_ce_rst", pc_ce, 0);
    tick(0, 0, 1, 1); sample();
    chk("t5_stale_req", bus.imem_req, 0);
    tick(0, 0, 1, 0); sample();
    chk("t5_stale_valid", bus.id_valid, 0);
    chk("t5_new_addr", bus.imem_addr, 16'h1234);

    // Throughput with always-ack memory
    reset_pc = 16'h0000; lat_min = 0; lat_max = 0;
    repeat (2) tick(1, 0, 1, 0);
    repeat (6) tick(0, 0, 1, 0);
    sample();
    c0 = ce_cnt;
    repeat (20) tick(0, 0, 1, 0);
    sample();
    chk("t6_throughput", ce_cnt - c0, B2B ? 20 : 10);

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      redirect_pc = AW'($urandom);
      reset_pc    = AW'($urandom);
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), 1'b0);
    end
    repeat (3) tick(0, 0, 1, 0);
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
